// File: rtl/rvv_backend_pkg.sv
// -----------------------------------------------------------------------------
// rvv_backend_pkg
// Shared backend definitions used by the reservation-station FIFOs:
//   - `NUM_DP_UOP : number of uops dispatch can hand over per cycle
//   - per-unit RS entry typedefs and default RS depths
//   - execution-unit class enumeration
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef NUM_DP_UOP
`define NUM_DP_UOP 2
`endif

package rvv_backend_pkg;

    localparam int RS_DWIDTH = 128;

    // Default reservation-station depths per execution-unit class.
    localparam int RS_DEPTH_ALU = 8;
    localparam int RS_DEPTH_MAC = 8;
    localparam int RS_DEPTH_PMT = 8;
    localparam int RS_DEPTH_DIV = 8;
    localparam int RS_DEPTH_LSU = 8;

    typedef enum logic [2:0] {
        UNIT_ALU = 3'd0,
        UNIT_MAC = 3'd1,
        UNIT_PMT = 3'd2,
        UNIT_DIV = 3'd3,
        UNIT_LSU = 3'd4
    } rvv_unit_e;

    // Issue-ready uop payloads; all classes currently share one width.
    typedef logic [RS_DWIDTH-1:0] alu_rs_entry_t;
    typedef logic [RS_DWIDTH-1:0] mac_rs_entry_t;
    typedef logic [RS_DWIDTH-1:0] pmt_rs_entry_t;
    typedef logic [RS_DWIDTH-1:0] div_rs_entry_t;
    typedef logic [RS_DWIDTH-1:0] lsu_rs_entry_t;

endpackage

// File: rtl/rvv_backend_rs_fifo_if.sv
// -----------------------------------------------------------------------------
// rvv_backend_rs_fifo_if
// Push (dispatch -> RS) and pop (RS -> issue) handshake bundle.
//   push_valid/push_data : per-port push request and payload, port 0 oldest
//   push_ready           : per-port space available
//   pop_valid/pop_data   : oldest entries presented, index 0 oldest
//   pop_ready            : issue consumes entry j
// Modports: master = dispatch/issue side, slave = the FIFO.
// -----------------------------------------------------------------------------
interface rvv_backend_rs_fifo_if #(
    parameter int DWIDTH = 128,
    parameter int N_PUSH = 2,
    parameter int N_POP  = 2
);
    logic [N_PUSH-1:0]             push_valid;
    logic [N_PUSH-1:0][DWIDTH-1:0] push_data;
    logic [N_PUSH-1:0]             push_ready;
    logic [N_POP-1:0]              pop_valid;
    logic [N_POP-1:0][DWIDTH-1:0]  pop_data;
    logic [N_POP-1:0]              pop_ready;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/rvv_backend_prefix_count.sv
// -----------------------------------------------------------------------------
// rvv_backend_prefix_count
// Counts the run of consecutive ones starting at bit 0 of i_vec; the first
// zero ends the run, so later ones are not counted.
//   i_vec : N-bit input vector
//   o_cnt : number of leading ones, 0..N
// -----------------------------------------------------------------------------
module rvv_backend_prefix_count #(
    parameter int N  = 2,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  i_vec,
    output logic [CW-1:0] o_cnt
);
    logic          w_run;
    logic [CW-1:0] w_cnt;

    // Walk from bit 0 and stop counting at the first zero.
    always_comb begin
        w_run = 1'b1;
        w_cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (w_run && i_vec[i]) begin
                w_cnt = w_cnt + CW'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign o_cnt = w_cnt;
endmodule

// File: rtl/rvv_backend_rs_fifo_chk.sv
// -----------------------------------------------------------------------------
// rvv_backend_rs_fifo_chk
// Occupancy bound checker for the RS FIFO: count + npush - npop must stay
// within [0, DEPTH] on every non-clearing edge.
//   i_clk, i_rst, i_clear : clock, reset, flush-or-reset
//   i_count, i_npush, i_npop : current occupancy and accepted push/pop counts
// -----------------------------------------------------------------------------
module rvv_backend_rs_fifo_chk #(
    parameter int DEPTH = 8,
    parameter int PW    = 4,
    parameter int NPW   = 2,
    parameter int NQW   = 2
) (
    input logic           i_clk,
    input logic           i_rst,
    input logic           i_clear,
    input logic [PW-1:0]  i_count,
    input logic [NPW-1:0] i_npush,
    input logic [NQW-1:0] i_npop
);
    a_count_le_depth : assert property (@(posedge i_clk) disable iff (i_rst || i_clear)
        (int'(i_count) + int'(i_npush) - int'(i_npop)) <= DEPTH);

    a_count_ge_zero : assert property (@(posedge i_clk) disable iff (i_rst || i_clear)
        (int'(i_count) + int'(i_npush) - int'(i_npop)) >= 0);
endmodule

// File: rtl/rvv_backend_rs_fifo.sv
// -----------------------------------------------------------------------------
// rvv_backend_rs_fifo
// Multi-push / multi-pop reservation-station FIFO between dispatch and the
// issue logic of one execution-unit class.
//   i_clk        : clock
//   i_rst        : synchronous active-high reset
//   i_flush      : synchronous clear of all entries
//   io_rs        : push/pop handshake bundle (slave modport)
//   o_fifo_count : occupancy, only when RVV_RS_FIFO_CNT_EN is defined
// push_ready and pop_valid are decoded from the registered count only, so no
// combinational path exists from push_valid or pop_ready to them.
// -----------------------------------------------------------------------------
import rvv_backend_pkg::*;

module rvv_backend_rs_fifo #(
    parameter int DWIDTH = 128,
    parameter int DEPTH  = 8,
    parameter int N_PUSH = `NUM_DP_UOP,
    parameter int N_POP  = 2,
    parameter int AW     = $clog2(DEPTH),
    parameter int PW     = AW + 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_flush,
`ifdef RVV_RS_FIFO_CNT_EN
    output logic [PW-1:0]  o_fifo_count,
`endif
    rvv_backend_rs_fifo_if.slave io_rs
);
    localparam int NPW = $clog2(N_PUSH + 1);
    localparam int NQW = $clog2(N_POP + 1);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_rptr;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_count;

    logic              w_clear;
    logic [N_PUSH-1:0] w_push_ready;
    logic [N_POP-1:0]  w_pop_valid;
    logic [N_PUSH-1:0] w_push_fire;
    logic [N_POP-1:0]  w_pop_fire;
    logic [NPW-1:0]    w_npush;
    logic [NQW-1:0]    w_npop;
    logic [AW-1:0]     w_widx [N_PUSH];
    logic [AW-1:0]     w_ridx [N_POP];

    assign w_clear = i_rst | i_flush;

    // Per-port readiness and validity from the registered occupancy.
    always_comb begin
        w_push_ready = '0;
        w_pop_valid  = '0;
        for (int i = 0; i < N_PUSH; i++) begin
            w_push_ready[i] = ((DEPTH - int'(r_count)) > i);
        end
        for (int j = 0; j < N_POP; j++) begin
            w_pop_valid[j] = (int'(r_count) > j);
        end
    end

    // Storage indices; the low pointer bits wrap naturally modulo DEPTH.
    always_comb begin
        for (int i = 0; i < N_PUSH; i++) begin
            w_widx[i] = r_wptr[AW-1:0] + AW'(i);
        end
        for (int j = 0; j < N_POP; j++) begin
            w_ridx[j] = r_rptr[AW-1:0] + AW'(j);
        end
    end

    assign w_push_fire = io_rs.push_valid & w_push_ready;
    assign w_pop_fire  = io_rs.pop_ready & w_pop_valid;

    rvv_backend_prefix_count #(.N(N_PUSH), .CW(NPW)) u_push_cnt (
        .i_vec (w_push_fire),
        .o_cnt (w_npush)
    );

    rvv_backend_prefix_count #(.N(N_POP), .CW(NQW)) u_pop_cnt (
        .i_vec (w_pop_fire),
        .o_cnt (w_npop)
    );

    // Pop outputs read straight from storage; data is meaningless when invalid.
    always_comb begin
        io_rs.push_ready = w_push_ready;
        io_rs.pop_valid  = w_pop_valid;
        for (int j = 0; j < N_POP; j++) begin
            io_rs.pop_data[j] = r_mem[w_ridx[j]];
        end
    end

    // Entry storage: only the leading accepted run of ports is written; not cleared on flush.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N_PUSH; i++) begin
            if (!w_clear && (i < int'(w_npush))) begin
                r_mem[w_widx[i]] <= io_rs.push_data[i];
            end
        end
    end

    // Pointers and occupancy; reset and flush are the same clear.
    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_rptr  <= r_rptr + PW'(w_npop);
            r_wptr  <= r_wptr + PW'(w_npush);
            r_count <= r_count + PW'(w_npush) - PW'(w_npop);
        end
    end

`ifdef RVV_RS_FIFO_CNT_EN
    assign o_fifo_count = r_count;
`endif

    rvv_backend_rs_fifo_chk #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .NPW   (NPW),
        .NQW   (NQW)
    ) u_chk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_clear),
        .i_count (r_count),
        .i_npush (w_npush),
        .i_npop  (w_npop)
    );
endmodule
